// File: rtl/sprite_overlay.sv
// Pipelined sprite overlay: rectangle hit test, sprite ROM addressing, blink and
// transparency, with a frame-synchronous position update handshake.
module sprite_overlay #(
  parameter int unsigned SPR_W           = 80,
  parameter int unsigned SPR_H           = 45,
  parameter int unsigned IDX_BITS        = 2,
  parameter int unsigned ROM_LAT         = 1,
  parameter int unsigned TRANSPARENT_IDX = 0,
  parameter int unsigned INIT_X          = 560,
  parameter int unsigned INIT_Y          = 434,
  parameter int unsigned BLINK_FRAMES    = 30,
  localparam int unsigned ADDR_W         = $clog2(SPR_W * SPR_H)
) (
  input  logic                vga_clk,
  input  logic                reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  input  logic                enable,
  input  logic                blink_en,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic                pos_valid,
  output logic                pos_ready,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [IDX_BITS-1:0] rom_q,
  output logic                sprite_on,
  output logic [IDX_BITS-1:0] sprite_index
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic hit;
    logic blank;
    logic en;
    logic visible;
  } qual_t;

  logic [9:0]          ax_q, ax_d, ay_q, ay_d;
  logic [9:0]          px_q, px_d, py_q, py_d;
  logic                pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vis_q, vis_d;
  logic                frame_start, hit;
  logic [9:0]          dx, dy;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  qual_t               qual_d, qual_a;
  qual_t               qual_q [ROM_LAT+1];
  logic                on_q, on_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign pos_ready   = !pend_q && !reset;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ax_d   = ax_q;
    ay_d   = ay_q;
    px_d   = px_q;
    py_d   = py_q;
    pend_d = pend_q;
    // A pending move lands only at frame start; ready is low while pending, so the branches never overlap.
    if (frame_start && pend_q) begin
      ax_d   = px_q;
      ay_d   = py_q;
      pend_d = 1'b0;
    end else if (pos_valid && pos_ready) begin
      px_d   = pos_x;
      py_d   = pos_y;
      pend_d = 1'b1;
    end

    cnt_d = cnt_q;
    vis_d = vis_q;
    if (!blink_en) begin
      cnt_d = '0;
      vis_d = 1'b1;
    end else if (frame_start) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d = '0;
        vis_d = ~vis_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Comparisons at 11 bits so a sprite near the right/bottom edge clips instead of wrapping.
  always_comb begin
    hit = ({1'b0, DrawX} >= {1'b0, ax_q}) && ({1'b0, DrawX} < ({1'b0, ax_q} + 11'(SPR_W))) &&
          ({1'b0, DrawY} >= {1'b0, ay_q}) && ({1'b0, DrawY} < ({1'b0, ay_q} + 11'(SPR_H)));
    dx  = DrawX - ax_q;
    dy  = DrawY - ay_q;
    rom_addr_d = hit ? (ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(SPR_W)) : '0;
    qual_d     = '{hit: hit, blank: blank, en: enable, visible: vis_q};
    qual_a     = qual_q[ROM_LAT];
    on_d       = qual_a.hit && qual_a.blank && qual_a.en && qual_a.visible &&
                 (rom_q != IDX_BITS'(TRANSPARENT_IDX));
    idx_d      = on_d ? rom_q : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ax_q       <= 10'(INIT_X);
      ay_q       <= 10'(INIT_Y);
      px_q       <= '0;
      py_q       <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      vis_q      <= 1'b1;
      rom_addr_q <= '0;
      on_q       <= 1'b0;
      idx_q      <= '0;
      // NOTE: the qualifier delay line is tiny and must read as "no hit" after reset, so it is reset too.
      for (int unsigned i = 0; i <= ROM_LAT; i++) qual_q[i] <= '0;
    end else begin
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      vis_q      <= vis_d;
      rom_addr_q <= rom_addr_d;
      qual_q[0]  <= qual_d;
      for (int unsigned i = 1; i <= ROM_LAT; i++) qual_q[i] <= qual_q[i-1];
      on_q       <= on_d;
      idx_q      <= idx_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sprite_on    = on_q;
  assign sprite_index = idx_q;

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed bench for sprite_overlay: hit/address, gating, handshake, clipping, blink, reset.
module tb_sprite_overlay;

  localparam int ADDR_W = 12;

  logic              vga_clk = 1'b0;
  logic              reset;
  logic [9:0]        DrawX, DrawY, pos_x, pos_y;
  logic              blank, enable, blink_en, pos_valid, pos_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0]        rom_q, rom_fill;
  logic              sprite_on;
  logic [1:0]        sprite_index;

  int n_pass  = 0;
  int n_total = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_overlay #(.BLINK_FRAMES(2)) dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .enable       (enable),
    .blink_en     (blink_en),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_valid    (pos_valid),
    .pos_ready    (pos_ready),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .sprite_on    (sprite_on),
    .sprite_index (sprite_index)
  );

  // Synchronous ROM, one cycle of latency, same value at every address.
  always @(posedge vga_clk) rom_q <= rom_fill;

  task automatic tick(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One pixel, then idle pixels; checks address at t+1, silence at t+2, output at t+3.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic bl, input logic en, input int e_addr,
                       input logic e_on, input logic [1:0] e_idx);
    DrawX = x; DrawY = y; blank = bl; enable = en;
    tick(1);
    check({tag, "_addr"}, 32'(rom_addr), 32'(e_addr));
    DrawX = 10'd5; DrawY = 10'd5; blank = 1'b1; enable = 1'b1;
    tick(1);
    check({tag, "_early"}, 32'(sprite_on), 32'd0);
    tick(1);
    check({tag, "_on"}, 32'(sprite_on), 32'(e_on));
    check({tag, "_idx"}, 32'(sprite_index), 32'(e_idx));
  endtask

  task automatic frame_start();
    DrawX = 10'd0; DrawY = 10'd0;
    tick(1);
    DrawX = 10'd5; DrawY = 10'd5;
  endtask

  task automatic offer(input logic [9:0] x, input logic [9:0] y);
    pos_x = x; pos_y = y; pos_valid = 1'b1;
    tick(1);
    pos_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; DrawX = 10'd5; DrawY = 10'd5; blank = 1'b1; enable = 1'b1;
    blink_en = 1'b0; pos_x = '0; pos_y = '0; pos_valid = 1'b0; rom_fill = 2'd2;
    tick(3);
    check("rst_ready", 32'(pos_ready), 32'd0);
    check("rst_on", 32'(sprite_on), 32'd0);
    check("rst_idx", 32'(sprite_index), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(pos_ready), 32'd1);
    tick(1);

    // Default position (560,434)
    probe("origin",    10'd560, 10'd434, 1'b1, 1'b1, 0,    1'b1, 2'd2);
    probe("far_corner",10'd639, 10'd478, 1'b1, 1'b1, 3599, 1'b1, 2'd2);
    probe("mid",       10'd600, 10'd450, 1'b1, 1'b1, 1320, 1'b1, 2'd2);
    probe("left_out",  10'd559, 10'd434, 1'b1, 1'b1, 0,    1'b0, 2'd0);
    probe("below_out", 10'd560, 10'd479, 1'b1, 1'b1, 0,    1'b0, 2'd0);

    // Transparency and gating
    rom_fill = 2'd0;
    probe("transparent", 10'd560, 10'd434, 1'b1, 1'b1, 0, 1'b0, 2'd0);
    rom_fill = 2'd3;
    probe("blank_off",  10'd561, 10'd434, 1'b0, 1'b1, 1, 1'b0, 2'd0);
    probe("enable_off", 10'd562, 10'd434, 1'b1, 1'b0, 2, 1'b0, 2'd0);
    probe("gates_on",   10'd563, 10'd434, 1'b1, 1'b1, 3, 1'b1, 2'd3);

    // Mid-frame request to (100,50)
    check("ready_before_req", 32'(pos_ready), 32'd1);
    offer(10'd100, 10'd50);
    check("ready_pending", 32'(pos_ready), 32'd0);
    probe("new_pos_early", 10'd100, 10'd50,  1'b1, 1'b1, 0, 1'b0, 2'd0);
    probe("old_pos_kept",  10'd560, 10'd434, 1'b1, 1'b1, 0, 1'b1, 2'd3);
    offer(10'd200, 10'd60);
    check("second_req_refused", 32'(pos_ready), 32'd0);
    DrawX = 10'd0; DrawY = 10'd0;
    #1;
    check("ready_at_fs", 32'(pos_ready), 32'd0);
    tick(1);
    DrawX = 10'd5; DrawY = 10'd5;
    check("ready_after_fs", 32'(pos_ready), 32'd1);
    probe("new_pos_hit",   10'd100, 10'd50,  1'b1, 1'b1, 0,    1'b1, 2'd3);
    probe("new_pos_far",   10'd179, 10'd94,  1'b1, 1'b1, 3599, 1'b1, 2'd3);
    probe("second_ignored",10'd200, 10'd60,  1'b1, 1'b1, 0,    1'b0, 2'd0);
    probe("old_pos_gone",  10'd560, 10'd434, 1'b1, 1'b1, 0,    1'b0, 2'd0);

    // Request offered on the frame-start cycle takes effect one frame later; clipping at (600,460)
    DrawX = 10'd0; DrawY = 10'd0; pos_x = 10'd600; pos_y = 10'd460; pos_valid = 1'b1;
    tick(1);
    pos_valid = 1'b0; DrawX = 10'd5; DrawY = 10'd5;
    check("fs_req_pending", 32'(pos_ready), 32'd0);
    probe("fs_req_not_yet", 10'd639, 10'd479, 1'b1, 1'b1, 0, 1'b0, 2'd0);
    frame_start();
    check("fs_req_ready", 32'(pos_ready), 32'd1);
    probe("clip_corner", 10'd639, 10'd479, 1'b1, 1'b1, 1559, 1'b1, 2'd3);
    probe("clip_nowrap", 10'd0,   10'd470, 1'b1, 1'b1, 0,    1'b0, 2'd0);

    // Blink with a two-frame half-period
    blink_en = 1'b1;
    tick(1);
    probe("blink_f0", 10'd600, 10'd460, 1'b1, 1'b1, 0, 1'b1, 2'd3);
    frame_start();
    probe("blink_f1", 10'd600, 10'd460, 1'b1, 1'b1, 0, 1'b1, 2'd3);
    frame_start();
    probe("blink_f2", 10'd600, 10'd460, 1'b1, 1'b1, 0, 1'b0, 2'd0);
    frame_start();
    probe("blink_f3", 10'd600, 10'd460, 1'b1, 1'b1, 0, 1'b0, 2'd0);
    frame_start();
    probe("blink_f4", 10'd600, 10'd460, 1'b1, 1'b1, 0, 1'b1, 2'd3);
    frame_start();
    probe("blink_f5", 10'd600, 10'd460, 1'b1, 1'b1, 0, 1'b1, 2'd3);
    frame_start();
    probe("blink_f6", 10'd600, 10'd460, 1'b1, 1'b1, 0, 1'b0, 2'd0);
    blink_en = 1'b0;
    tick(1);
    probe("blink_off", 10'd600, 10'd460, 1'b1, 1'b1, 0, 1'b1, 2'd3);

    // Reset mid-frame with a pending request
    check("ready_before_rst_req", 32'(pos_ready), 32'd1);
    offer(10'd300, 10'd200);
    DrawX = 10'd600; DrawY = 10'd460;
    tick(3);
    check("pre_rst_on", 32'(sprite_on), 32'd1);
    reset = 1'b1;
    #1;
    check("in_rst_ready", 32'(pos_ready), 32'd0);
    tick(1);
    check("rst2_on", 32'(sprite_on), 32'd0);
    check("rst2_idx", 32'(sprite_index), 32'd0);
    check("rst2_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    #1;
    check("rst2_ready", 32'(pos_ready), 32'd1);
    DrawX = 10'd5; DrawY = 10'd5;
    tick(3);
    frame_start();
    probe("discarded_req", 10'd300, 10'd200, 1'b1, 1'b1, 0,    1'b0, 2'd0);
    probe("init_pos_back", 10'd560, 10'd434, 1'b1, 1'b1, 0,    1'b1, 2'd3);
    probe("init_pos_far",  10'd639, 10'd478, 1'b1, 1'b1, 3599, 1'b1, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
